// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the 4-slot TDM receive path
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  typedef enum logic {HUNT, LOCKED} tdm_state_t;
  typedef logic [SLOT_W-1:0] tdm_slot_t;
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial-in / 4-lane-out bundle for the TDM demultiplexer
interface tdm_demux4_if
  import tdm_pkg::*;
#(parameter int W = 1);
  logic en;
  logic [W-1:0] sin;
  logic sync;
  logic [NUM_SLOTS*W-1:0] dout;
  logic valid;
  tdm_slot_t slot;
  logic locked;
  logic sync_err;
  modport master (output en, sin, sync, input dout, valid, slot, locked, sync_err);
  modport slave (input en, sin, sync, output dout, valid, slot, locked, sync_err);
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit wrapping slot counter with a load-to-1 override
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      load1_i,
  output tdm_slot_t cnt_o,
  output logic      last_o
);
  tdm_slot_t cnt_q, cnt_d;
  always_comb cnt_d = load1_i ? tdm_slot_t'(1) : en_i ? cnt_q + tdm_slot_t'(1) : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign last_o = cnt_q == tdm_slot_t'(NUM_SLOTS - 1);
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 1-to-4 TDM demultiplexer aligned to a frame-sync marker,
// publishing a registered 4-lane word with a one-cycle valid per frame.
module tdm_demux4
  import tdm_pkg::*;
#(parameter int W = 1)
(
  input logic clk,
  input logic rst,
  tdm_demux4_if.slave bus
);
  tdm_state_t state_q, state_d;
  logic [NUM_SLOTS-2:0][W-1:0] stage_q, stage_d;
  logic [NUM_SLOTS*W-1:0] dout_q, dout_d;
  logic valid_q, valid_d, err_q, err_d;
  logic load1, inc, last;
  tdm_slot_t slot;
  tdm_slot_ctr u_ctr (
    .clk(clk), .rst(rst), .en_i(inc), .load1_i(load1), .cnt_o(slot), .last_o(last)
  );
  // Any accepted sync restarts the frame at slot 0, which leaves the counter at 1.
  always_comb begin
    load1 = bus.en & bus.sync & (state_q == HUNT | slot != '0);
    inc = bus.en & (state_q == LOCKED) & ~load1;
    valid_d = inc & last;
    err_d = load1 & (state_q == LOCKED);
    state_d = load1 ? LOCKED : state_q;
    dout_d = valid_d ? {bus.sin, stage_q} : dout_q;
    stage_d = stage_q;
    for (int i = 0; i < NUM_SLOTS - 1; i++)
      if ((load1 && i == 0) || (inc && slot == tdm_slot_t'(i))) stage_d[i] = bus.sin;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= HUNT;
      stage_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign bus.dout = dout_q;
  assign bus.valid = valid_q;
  assign bus.slot = slot;
  assign bus.locked = state_q == LOCKED;
  assign bus.sync_err = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenario checks for tdm_demux4 at W=1
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  tdm_demux4_if #(.W(1)) bus();
  tdm_demux4 #(.W(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic drive(input logic e, input logic s, input logic d);
    bus.en = e;
    bus.sync = s;
    bus.sin = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    checks++; if (bus.dout !== 4'b0000) $display("FAIL reset_dout got %b want 0000", bus.dout); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid); else passed++;
    checks++; if (bus.slot !== 2'd0) $display("FAIL reset_slot got %0d want 0", bus.slot); else passed++;
    checks++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got %b want 0", bus.locked); else passed++;
    checks++; if (bus.sync_err !== 1'b0) $display("FAIL reset_sync_err got %b want 0", bus.sync_err); else passed++;
  endtask

  task automatic test_hunt_ignore;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      checks++; if (bus.locked !== 1'b0 || bus.valid !== 1'b0 || bus.dout !== 4'b0000 || bus.slot !== 2'd0)
        $display("FAIL hunt_ignore cycle %0d got locked=%b valid=%b dout=%b slot=%0d want 0/0/0000/0", i, bus.locked, bus.valid, bus.dout, bus.slot);
      else passed++;
    end
  endtask

  task automatic test_frame;
    drive(1'b1, 1'b1, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.slot !== 2'd1) $display("FAIL frame_lock got locked=%b slot=%0d want 1/1", bus.locked, bus.slot); else passed++;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b0 || bus.dout !== 4'b0000) $display("FAIL frame_early got valid=%b dout=%b want 0/0000", bus.valid, bus.dout); else passed++;
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b1 || bus.dout !== 4'b0001 || bus.slot !== 2'd0)
      $display("FAIL frame1 got valid=%b dout=%b slot=%0d want 1/0001/0", bus.valid, bus.dout, bus.slot); else passed++;
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (bus.valid !== 1'b0 || bus.dout !== 4'b0001 || bus.sync_err !== 1'b0)
      $display("FAIL back_to_back_hold got valid=%b dout=%b err=%b want 0/0001/0", bus.valid, bus.dout, bus.sync_err); else passed++;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (bus.valid !== 1'b1 || bus.dout !== 4'b1000) $display("FAIL frame2 got valid=%b dout=%b want 1/1000", bus.valid, bus.dout); else passed++;
  endtask

  task automatic test_en_toggle;
    logic [3:0] bits = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) drive(1'b1, i == 0, bits[i/2]);
      else begin
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (bus.slot !== 2'((i + 1) / 2) || bus.valid !== 1'b0)
          $display("FAIL en_toggle_hold cycle %0d got slot=%0d valid=%b want %0d/0", i, bus.slot, bus.valid, (i + 1) / 2);
        else passed++;
      end
    end
    checks++; if (bus.valid !== 1'b1 || bus.dout !== 4'b0110) $display("FAIL en_toggle_frame got valid=%b dout=%b want 1/0110", bus.valid, bus.dout); else passed++;
    drive(1'b0, 1'b0, 1'b1);
    checks++; if (bus.valid !== 1'b0 || bus.dout !== 4'b0110) $display("FAIL en_toggle_pulse got valid=%b dout=%b want 0/0110", bus.valid, bus.dout); else passed++;
  endtask

  task automatic test_misalign;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (bus.slot !== 2'd2) $display("FAIL misalign_pre got slot=%0d want 2", bus.slot); else passed++;
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (bus.sync_err !== 1'b1 || bus.valid !== 1'b0 || bus.slot !== 2'd1 || bus.locked !== 1'b1)
      $display("FAIL misalign_err got err=%b valid=%b slot=%0d locked=%b want 1/0/1/1", bus.sync_err, bus.valid, bus.slot, bus.locked); else passed++;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.sync_err !== 1'b0 || bus.slot !== 2'd1) $display("FAIL misalign_pulse got err=%b slot=%0d want 0/1", bus.sync_err, bus.slot); else passed++;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b0 || bus.dout !== 4'b0110) $display("FAIL misalign_no_valid got valid=%b dout=%b want 0/0110", bus.valid, bus.dout); else passed++;
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (bus.valid !== 1'b1 || bus.dout !== 4'b1010) $display("FAIL misalign_frame got valid=%b dout=%b want 1/1010", bus.valid, bus.dout); else passed++;
  endtask

  task automatic test_rst_mid;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    checks++; if (bus.slot !== 2'd0 || bus.locked !== 1'b0 || bus.dout !== 4'b0000 || bus.valid !== 1'b0)
      $display("FAIL rst_mid got slot=%0d locked=%b dout=%b valid=%b want 0/0/0000/0", bus.slot, bus.locked, bus.dout, bus.valid); else passed++;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
    checks++; if (bus.slot !== 2'd0 || bus.locked !== 1'b0 || bus.valid !== 1'b0)
      $display("FAIL rst_mid_hunt got slot=%0d locked=%b valid=%b want 0/0/0", bus.slot, bus.locked, bus.valid); else passed++;
  endtask

  task automatic test_sync_no_en;
    drive(1'b0, 1'b1, 1'b1);
    checks++; if (bus.locked !== 1'b0 || bus.slot !== 2'd0) $display("FAIL sync_no_en got locked=%b slot=%0d want 0/0", bus.locked, bus.slot); else passed++;
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (bus.locked !== 1'b0) $display("FAIL sync_no_en_after got locked=%b want 0", bus.locked); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.sin = 1'b0;
    test_reset;
    test_hunt_ignore;
    test_frame;
    test_en_toggle;
    test_misalign;
    test_rst_mid;
    test_sync_no_en;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
